// File: rtl/ddr2pe_pkg.sv
// ddr2pe_pkg: opcodes, buffer indices, FSM states and instruction field offsets
// shared by the DDR-to-PE dispatcher.
package ddr2pe_pkg;

    localparam logic [3:0] RD_OP_D    = 4'h0;
    localparam logic [3:0] RD_OP_I    = 4'h1;
    localparam logic [3:0] RD_OP_G    = 4'h4;
    localparam logic [3:0] RD_OP_W    = 4'h5;
    localparam logic [3:0] RD_OP_DW   = 4'h8;
    localparam logic [3:0] RD_OP_DB   = 4'h9;
    localparam logic [3:0] RD_OP_TW   = 4'hA;
    localparam logic [3:0] RD_OP_TB   = 4'hB;
    localparam logic [3:0] RD_OP_SYNC = 4'hF;

    localparam int BUF_I = 0;
    localparam int BUF_D = 1;
    localparam int BUF_P = 2;
    localparam int BUF_A = 3;

    localparam int OP_LSB     = 58;
    localparam int BUF_ID_LSB = 52;
    localparam int DEPOOL_BIT = 48;
    localparam int ROW_LSB    = 44;
    localparam int PIX_LSB    = 40;
    localparam int SIZE_LSB   = 32;
    localparam int ADDR_LSB   = 0;

    typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_e;

    typedef struct packed {
        logic       sync;
        logic       row;
        logic [3:0] need;
    } dec_t;

    function automatic logic op_valid(input logic [3:0] op);
        return op inside {RD_OP_D, RD_OP_I, RD_OP_G, RD_OP_W, RD_OP_DW,
                          RD_OP_DB, RD_OP_TW, RD_OP_TB, RD_OP_SYNC};
    endfunction

    function automatic dec_t decode(input logic [3:0] op, input logic [3:0] lt);
        dec_t d;
        d = '0;
        case (op)
            RD_OP_D, RD_OP_G: begin
                d.need[BUF_D] = 1'b1;
                d.row         = 1'b1;
            end
            RD_OP_I:                     d.need[BUF_I] = 1'b1;
            RD_OP_W:                     d.need[BUF_P] = 1'b1;
            RD_OP_DW:                    d.need[lt[2:1] != 2'b10 ? BUF_P : BUF_A] = 1'b1;
            RD_OP_DB, RD_OP_TW, RD_OP_TB: d.need[BUF_A] = 1'b1;
            RD_OP_SYNC:                  d.sync = 1'b1;
            default:                     d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ddr2pe_busy_track.sv
// ddr2pe_busy_track: N-bit busy register set by start and cleared by done;
// a done on an idle bit is flagged as spurious and otherwise ignored.
module ddr2pe_busy_track #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] set_i,
    input  logic [N-1:0] done_i,
    output logic [N-1:0] busy_o,
    output logic         spurious_o
);

    logic [N-1:0] busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= (busy_q & ~done_i) | set_i;
    end

    assign busy_o     = busy_q;
    assign spurious_o = |(done_i & ~busy_q);

endmodule

// File: rtl/ddr2pe_dispatch.sv
// ddr2pe_dispatch: decodes read instructions into buffer-loader and DDR-channel starts.
// Optional WAIT-cycle counter enabled by DDR2PE_STALL_CNT_EN.
module ddr2pe_dispatch
    import ddr2pe_pkg::*;
#(
    parameter int PE_NUM  = 16,
    parameter int DDR_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int BURST_W = 8,
    parameter int INST_W  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         layer_type,
    input  logic [7:0]         image_width,
    input  logic [3:0]         in_ch_seg,
    input  logic               ins_valid,
    output logic               ins_ready,
    input  logic [INST_W-1:0]  ins,
    output logic [3:0]         buf_start,
    input  logic [3:0]         buf_done,
    output logic [3:0]         buf_conf_mode,
    output logic [7:0]         buf_conf_num,
    output logic [3:0]         buf_conf_row,
    output logic [3:0]         buf_conf_pix,
    output logic               buf_conf_depool,
    output logic [PE_NUM-1:0]  buf_conf_mask,
    output logic [DDR_CH-1:0]  ddr_start,
    input  logic [DDR_CH-1:0]  ddr_done,
    output logic [ADDR_W-1:0]  ddr_st_addr,
    output logic [BURST_W-1:0] ddr_burst,
    output logic [ADDR_W-1:0]  ddr_step,
    output logic [BURST_W-1:0] ddr_burst_num,
    output logic               all_idle,
    output logic               err,
    output logic [31:0]        stall_cycles
);

    state_e              state_q, state_d;
    logic [3:0]          op_q, lt_q, row_q, pix_q, seg_q;
    logic [5:0]          bid_q;
    logic                dp_q;
    logic [7:0]          size_q, iw_q;
    logic [31:0]         addr_q;
    logic [3:0]          buf_start_q, buf_start_d, buf_need, buf_busy;
    logic [DDR_CH-1:0]   ddr_start_q, ddr_start_d, ddr_need, ddr_busy;
    logic [3:0]          mode_q, row_o_q, pix_o_q;
    logic [7:0]          num_q;
    logic                depool_q, err_q;
    logic [PE_NUM-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0]   st_addr_q, step_q;
    logic [BURST_W-1:0]  burst_q, bnum_q;
    dec_t                dec;
    logic [1:0]          ch;
    logic                accept, bad, go, issue, buf_spur, ddr_spur;
    logic [12:0]         burst_full;
    logic [16:0]         step_full;
    logic                unused_ins;

    // Starts are registered on the WAIT exit, so the ISSUE pulse shares its
    // cycle with the return to IDLE and the next accept can land there.
    always_comb begin
        accept      = ins_valid && state_q == IDLE;
        bad         = accept && !op_valid(ins[OP_LSB+:4]);
        dec         = decode(op_q, lt_q);
        ch          = 2'(int'(op_q[3:2]) % DDR_CH);
        buf_need    = dec.sync ? 4'hF : dec.need;
        ddr_need    = dec.sync ? '1 : DDR_CH'(1) << ch;
        go          = ~|(buf_busy & ~buf_done & buf_need) && ~|(ddr_busy & ~ddr_done & ddr_need);
        issue       = state_q == WAIT && go;
        buf_start_d = issue && !dec.sync ? buf_need : '0;
        ddr_start_d = issue && !dec.sync ? ddr_need : '0;
        state_d     = accept && !bad ? WAIT : issue ? IDLE : state_q;
        mask_d      = dec.need[BUF_D] ? '1 :
                      lt_q[0] ? PE_NUM'(1) << bid_q : PE_NUM'(4'hF) << {bid_q, 2'b00};
        burst_full  = (13'(pix_q) * 13'(seg_q)) << 5;
        step_full   = (17'(pix_q) * 17'(iw_q)) << 5;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            {op_q, lt_q, row_q, pix_q, seg_q, bid_q, dp_q, size_q, iw_q, addr_q} <= '0;
            buf_start_q <= '0;
            ddr_start_q <= '0;
            err_q       <= 1'b0;
            {mode_q, num_q, row_o_q, pix_o_q, depool_q} <= '0;
            mask_q      <= '0;
            st_addr_q   <= '0;
            step_q      <= '0;
            burst_q     <= '0;
            bnum_q      <= '0;
        end else begin
            state_q     <= state_d;
            buf_start_q <= buf_start_d;
            ddr_start_q <= ddr_start_d;
            err_q       <= bad || buf_spur || ddr_spur;
            if (accept) begin
                op_q   <= ins[OP_LSB+:4];
                bid_q  <= ins[BUF_ID_LSB+:6];
                dp_q   <= ins[DEPOOL_BIT];
                row_q  <= ins[ROW_LSB+:4];
                pix_q  <= ins[PIX_LSB+:4];
                size_q <= ins[SIZE_LSB+:8];
                addr_q <= ins[ADDR_LSB+:32];
                lt_q   <= layer_type;
                iw_q   <= image_width;
                seg_q  <= in_ch_seg;
            end
            if (issue && !dec.sync) begin
                {mode_q, num_q, row_o_q, pix_o_q, depool_q} <= {lt_q, size_q, row_q, pix_q, dp_q};
                mask_q    <= mask_d;
                st_addr_q <= ADDR_W'(addr_q);
                burst_q   <= dec.row ? BURST_W'(burst_full) : BURST_W'(size_q);
                step_q    <= dec.row ? ADDR_W'(step_full) : '0;
                bnum_q    <= dec.row ? BURST_W'(row_q) : BURST_W'(1);
            end
        end
    end

    ddr2pe_busy_track #(.N(4)) u_buf_busy (
        .clk        (clk),
        .rst_n      (rst),
        .set_i      (buf_start_d),
        .done_i     (buf_done),
        .busy_o     (buf_busy),
        .spurious_o (buf_spur)
    );

    ddr2pe_busy_track #(.N(DDR_CH)) u_ddr_busy (
        .clk        (clk),
        .rst_n      (rst),
        .set_i      (ddr_start_d),
        .done_i     (ddr_done),
        .busy_o     (ddr_busy),
        .spurious_o (ddr_spur)
    );

`ifdef DDR2PE_STALL_CNT_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                   stall_q <= '0;
        else if (state_q == WAIT && stall_q != '1)  stall_q <= stall_q + 32'd1;
    end
    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

    assign unused_ins      = ^ins;
    assign ins_ready       = state_q == IDLE;
    assign all_idle        = state_q == IDLE && ~|buf_busy && ~|ddr_busy;
    assign err             = err_q;
    assign buf_start       = buf_start_q;
    assign ddr_start       = ddr_start_q;
    assign buf_conf_mode   = mode_q;
    assign buf_conf_num    = num_q;
    assign buf_conf_row    = row_o_q;
    assign buf_conf_pix    = pix_o_q;
    assign buf_conf_depool = depool_q;
    assign buf_conf_mask   = mask_q;
    assign ddr_st_addr     = st_addr_q;
    assign ddr_burst       = burst_q;
    assign ddr_step        = step_q;
    assign ddr_burst_num   = bnum_q;

endmodule

// File: tb/tb_ddr2pe_dispatch.sv
// tb_ddr2pe_dispatch: directed stimulus with a queue-based scoreboard; a monitor
// compares every start/err event the dispatcher emits against the expected queue.
module tb_ddr2pe_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  layer_type;
    logic [7:0]  image_width;
    logic [3:0]  in_ch_seg;
    logic        ins_valid;
    logic        ins_ready;
    logic [63:0] ins;
    logic [3:0]  buf_start, buf_done, buf_conf_mode, buf_conf_row, buf_conf_pix;
    logic [7:0]  buf_conf_num;
    logic        buf_conf_depool;
    logic [15:0] buf_conf_mask;
    logic [1:0]  ddr_start, ddr_done;
    logic [31:0] ddr_st_addr, ddr_step, stall_cycles;
    logic [7:0]  ddr_burst, ddr_burst_num;
    logic        all_idle, err;

    ddr2pe_dispatch dut (
        .clk(clk), .rst(rst), .layer_type(layer_type), .image_width(image_width),
        .in_ch_seg(in_ch_seg), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
        .buf_start(buf_start), .buf_done(buf_done), .buf_conf_mode(buf_conf_mode),
        .buf_conf_num(buf_conf_num), .buf_conf_row(buf_conf_row), .buf_conf_pix(buf_conf_pix),
        .buf_conf_depool(buf_conf_depool), .buf_conf_mask(buf_conf_mask),
        .ddr_start(ddr_start), .ddr_done(ddr_done), .ddr_st_addr(ddr_st_addr),
        .ddr_burst(ddr_burst), .ddr_step(ddr_step), .ddr_burst_num(ddr_burst_num),
        .all_idle(all_idle), .err(err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          e;
        logic [3:0]  bs;
        logic [1:0]  ds;
        logic [15:0] mask;
        logic [7:0]  burst;
        logic [31:0] step;
        logic [7:0]  bnum;
        logic [31:0] addr;
        logic [20:0] conf;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [20:0] lc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] b, input logic [1:0] d);
        buf_done = b;
        ddr_done = d;
        tick(1);
        buf_done = '0;
        ddr_done = '0;
    endtask

    task automatic send(input logic [3:0] op, input logic [5:0] bid, input logic dp,
                        input logic [3:0] row, input logic [3:0] pix, input logic [7:0] sz,
                        input logic [31:0] ad, output int t);
        ins       = {2'b11, op, bid, 3'b000, dp, row, pix, sz, ad};
        lc        = {layer_type, sz, row, pix, dp};
        ins_valid = 1'b1;
        t         = -1;
        for (int n = 0; n < 100 && t < 0; n++) begin
            @(negedge clk);
            if (ins_ready) t = cyc;
            @(posedge clk);
            #1;
        end
        ins_valid = 1'b0;
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout op=%0h never accepted", op);
        end
    endtask

    task automatic push_start(input logic [3:0] bs, input logic [1:0] ds, input logic [15:0] mask,
                              input logic [7:0] burst, input logic [31:0] step,
                              input logic [7:0] bnum, input logic [31:0] addr, input int c);
        exp_t e;
        e = '{e: 1'b0, bs: bs, ds: ds, mask: mask, burst: burst, step: step, bnum: bnum,
              addr: addr, conf: lc, cyc: c};
        q.push_back(e);
    endtask

    task automatic push_err(input int c);
        exp_t e;
        e = '{e: 1'b1, bs: '0, ds: '0, mask: '0, burst: '0, step: '0, bnum: '0,
              addr: '0, conf: '0, cyc: c};
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && (|buf_start || |ddr_start || err)) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {buf_start, ddr_start, err}, 0);
            end else begin
                e = q.pop_front();
                chk("event_cycle", 64'(cyc), 64'(e.cyc));
                chk("err", err, e.e);
                chk("buf_start", buf_start, e.bs);
                chk("ddr_start", ddr_start, e.ds);
                if (!e.e) begin
                    chk("buf_conf_mask", buf_conf_mask, e.mask);
                    chk("ddr_burst", ddr_burst, e.burst);
                    chk("ddr_step", ddr_step, e.step);
                    chk("ddr_burst_num", ddr_burst_num, e.bnum);
                    chk("ddr_st_addr", ddr_st_addr, e.addr);
                    chk("buf_conf", {buf_conf_mode, buf_conf_num, buf_conf_row, buf_conf_pix,
                                     buf_conf_depool}, e.conf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, s0;
        rst = 1'b0; ins_valid = 1'b0; ins = '0; buf_done = '0; ddr_done = '0;
        layer_type = '0; image_width = '0; in_ch_seg = '0;
        tick(3);
        chk("rst_ins_ready", ins_ready, 1);
        chk("rst_all_idle", all_idle, 1);
        chk("rst_outputs", {buf_start, ddr_start, err, buf_conf_mask, ddr_burst, ddr_step,
                            ddr_burst_num, ddr_st_addr, stall_cycles}, 0);
        rst = 1'b1;
        tick(1);
        chk("post_rst_ready", ins_ready, 1);

        // RD_OP_I, channel 0, single-bit mask
        layer_type = 4'd1;
        send(4'h1, 6'd3, 1'b0, 4'd0, 4'd0, 8'd20, 32'h1000, t);
        push_start(4'b0001, 2'b01, 16'h0008, 8'd20, 32'd0, 8'd1, 32'h1000, t + 2);
        tick(3);
        pulse(4'b0001, 2'b01);
        chk("idle_after_i", all_idle, 1);

        // Two RD_OP_W back to back: second waits on p and channel 1
        layer_type = 4'd0;
        send(4'h5, 6'd1, 1'b0, 4'd0, 4'd0, 8'd8, 32'h2000, t);
        push_start(4'b0100, 2'b10, 16'h00F0, 8'd8, 32'd0, 8'd1, 32'h2000, t + 2);
        send(4'h5, 6'd2, 1'b0, 4'd0, 4'd0, 8'd9, 32'h3000, t2);
        chk("accept_at_t_plus_2", 64'(t2), 64'(t + 2));
        push_start(4'b0100, 2'b10, 16'h0F00, 8'd9, 32'd0, 8'd1, 32'h3000, t2 + 8);
        s0 = int'(stall_cycles);
        chk("w_wait_ready_low", ins_ready, 0);
        tick(6);
        chk("w_still_waiting", ins_ready, 0);
        pulse(4'b0100, 2'b10);
        chk("ready_after_w_issue", ins_ready, 1);
`ifdef DDR2PE_STALL_CNT_EN
        chk("stall_delta", 64'(int'(stall_cycles) - s0), 7);
`else
        chk("stall_zero", stall_cycles, 0);
`endif
        tick(1);
        pulse(4'b0100, 2'b10);
        chk("idle_after_w", all_idle, 1);

        // RD_OP_D row op, then SYNC behind it
        layer_type = 4'd1; image_width = 8'd10; in_ch_seg = 4'd2;
        send(4'h0, 6'd0, 1'b1, 4'd4, 4'd3, 8'h55, 32'h4000, t);
        push_start(4'b0010, 2'b01, 16'hFFFF, 8'd192, 32'd960, 8'd4, 32'h4000, t + 2);
        send(4'hF, 6'd0, 1'b0, 4'd0, 4'd0, 8'd0, 32'h0, t);
        tick(3);
        chk("sync_ready_low", ins_ready, 0);
        chk("sync_not_idle", all_idle, 0);
        pulse(4'b0000, 2'b01);
        chk("sync_wait_d", ins_ready, 0);
        pulse(4'b0010, 2'b00);
        chk("sync_released", ins_ready, 1);
        chk("sync_all_idle", all_idle, 1);

        // Illegal opcode and stray done
        send(4'h3, 6'd0, 1'b0, 4'd0, 4'd0, 8'd1, 32'h0, t);
        push_err(t + 1);
        tick(2);
        chk("bad_op_ready", ins_ready, 1);
        push_err(cyc + 1);
        pulse(4'b1000, 2'b00);
        tick(2);

        // RD_OP_DW: target a when layer_type[2:1]==2'b10, else p
        layer_type = 4'b0100;
        send(4'h8, 6'd2, 1'b0, 4'd0, 4'd0, 8'd5, 32'h5000, t);
        push_start(4'b1000, 2'b01, 16'h0F00, 8'd5, 32'd0, 8'd1, 32'h5000, t + 2);
        tick(3);
        pulse(4'b1000, 2'b01);
        layer_type = 4'd0;
        send(4'h8, 6'd5, 1'b0, 4'd0, 4'd0, 8'd6, 32'h6000, t);
        push_start(4'b0100, 2'b01, 16'h0000, 8'd6, 32'd0, 8'd1, 32'h6000, t + 2);
        tick(3);
        pulse(4'b0100, 2'b01);

        // RD_OP_G with truncating burst, channel 1
        layer_type = 4'd1; image_width = 8'd255; in_ch_seg = 4'd15;
        send(4'h4, 6'd0, 1'b0, 4'd15, 4'd15, 8'd7, 32'h7000, t);
        push_start(4'b0010, 2'b10, 16'hFFFF, 8'd32, 32'd122400, 8'd15, 32'h7000, t + 2);
        tick(3);
        pulse(4'b0010, 2'b10);
        chk("idle_after_g", all_idle, 1);

        // Reset mid-operation: in-flight done becomes spurious
        send(4'h1, 6'd0, 1'b0, 4'd0, 4'd0, 8'd3, 32'h8000, t);
        push_start(4'b0001, 2'b01, 16'h0001, 8'd3, 32'd0, 8'd1, 32'h8000, t + 2);
        tick(3);
        chk("busy_before_rst", all_idle, 0);
        rst = 1'b0;
        tick(1);
        chk("rst_mid_idle", all_idle, 1);
        chk("rst_mid_mask", buf_conf_mask, 0);
        rst = 1'b1;
        tick(1);
        push_err(cyc + 1);
        pulse(4'b0001, 2'b00);
        tick(3);
        chk("queue_empty", 64'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
